// File: rtl/serial_subtractor_4bit_if.sv
// serial_subtractor_4bit_if: start/busy/done operand and result bundle for the serial subtractor.
// Ports: start_i request, a_i minuend, b_i subtrahend, bin_i borrow-in (master drives);
//        diff_o result, bout_o borrow-out, busy_o in-flight flag, done_o completion pulse (slave drives).
interface serial_subtractor_4bit_if #(
    parameter int WIDTH = 4
);
    logic             start_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             bin_i;
    logic [WIDTH-1:0] diff_o;
    logic             bout_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output start_i, a_i, b_i, bin_i,
        input  diff_o, bout_o, busy_o, done_o
    );

    modport slave (
        input  start_i, a_i, b_i, bin_i,
        output diff_o, bout_o, busy_o, done_o
    );
endinterface

// File: rtl/serial_subtractor_4bit.sv
// serial_subtractor_4bit: bit-serial a - b - bin, LSB first, one full-subtractor cell plus a borrow flop.
// Ports: clk rising-edge clock; rst_n asynchronous active-low reset;
//        bus (slave) start_i/a_i/b_i/bin_i in, diff_o/bout_o/busy_o/done_o out, all outputs registered.
module serial_subtractor_4bit #(
    parameter int WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    serial_subtractor_4bit_if.slave   bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             busy_q;
    logic             done_q;

    logic             bit_d;
    logic             br_d;
    logic [WIDTH-1:0] res_d;

    always_comb begin
        bit_d = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
        br_d  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
        res_d = {bit_d, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        a_sh_q  <= bus.a_i;
                        b_sh_q  <= bus.b_i;
                        br_q    <= bus.bin_i;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q <= a_sh_q >> 1;
                    b_sh_q <= b_sh_q >> 1;
                    res_q  <= res_d;
                    br_q   <= br_d;
                    cnt_q  <= cnt_q + CW'(1);
                    // Final bit goes straight into diff so the result is visible with done.
                    if (cnt_q == LAST) begin
                        diff_q  <= res_d;
                        bout_q  <= br_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.diff_o = diff_q;
    assign bus.bout_o = bout_q;
    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
endmodule
